// File: rtl/l2_line_cache.sv
// ============================================================================
// Module   : l2_line_cache
// Purpose  : Direct-mapped write-back/write-allocate L2 line cache between L1
//            and memory; define L2_WRITE_THROUGH_EN for write-through/no-allocate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module l2_line_cache #(
  parameter int NUM_OF_SET = 8
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         l1_read,
  input  logic         l1_write,
  input  logic [27:0]  l1_addr,
  input  logic [127:0] l1_wdata,
  output logic [127:0] l1_rdata,
  output logic         l1_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int IDX_W = $clog2(NUM_OF_SET);
  localparam int TAG_W = 28 - IDX_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MWR   = 3'd1;  // write-back of victim, or write-through
  localparam logic [2:0] ST_ALLOC = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [127:0]     rdata_q, rdata_d;
  logic             valid_q [NUM_OF_SET];
  logic             valid_d [NUM_OF_SET];
  logic [TAG_W-1:0] tag_q   [NUM_OF_SET];
  logic [TAG_W-1:0] tag_d   [NUM_OF_SET];
  logic [127:0]     data_q  [NUM_OF_SET];
  logic [127:0]     data_d  [NUM_OF_SET];
`ifndef L2_WRITE_THROUGH_EN
  logic             dirty_q [NUM_OF_SET];
  logic             dirty_d [NUM_OF_SET];
`endif

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_req;

  assign w_idx = l1_addr[IDX_W-1:0];
  assign w_tag = l1_addr[27:IDX_W];
  assign w_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  assign w_req = l1_read | l1_write;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
`ifndef L2_WRITE_THROUGH_EN
    dirty_d = dirty_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
`ifdef L2_WRITE_THROUGH_EN
          if (l1_write) begin
            if (w_hit) data_d[w_idx] = l1_wdata;
            state_d = ST_MWR;
          end else if (w_hit) begin
            rdata_d = data_q[w_idx];
            state_d = ST_RESP;
          end else begin
            state_d = ST_ALLOC;
          end
`else
          if (w_hit) begin
            if (l1_write) begin
              data_d[w_idx]  = l1_wdata;
              dirty_d[w_idx] = 1'b1;
            end else begin
              rdata_d = data_q[w_idx];
            end
            state_d = ST_RESP;
          end else if (valid_q[w_idx] && dirty_q[w_idx]) begin
            state_d = ST_MWR;
          end else if (l1_write) begin
            valid_d[w_idx] = 1'b1;
            dirty_d[w_idx] = 1'b1;
            tag_d[w_idx]   = w_tag;
            data_d[w_idx]  = l1_wdata;
            state_d        = ST_RESP;
          end else begin
            state_d = ST_ALLOC;
          end
`endif
        end
      end
      ST_MWR: begin
        if (mem_ready) begin
`ifdef L2_WRITE_THROUGH_EN
          state_d = ST_RESP;
`else
          dirty_d[w_idx] = 1'b0;
          if (l1_write) begin
            valid_d[w_idx] = 1'b1;
            dirty_d[w_idx] = 1'b1;
            tag_d[w_idx]   = w_tag;
            data_d[w_idx]  = l1_wdata;
            state_d        = ST_RESP;
          end else begin
            state_d = ST_ALLOC;
          end
`endif
        end
      end
      ST_ALLOC: begin
        if (mem_ready) begin
          valid_d[w_idx] = 1'b1;
          tag_d[w_idx]   = w_tag;
          data_d[w_idx]  = mem_rdata;
`ifndef L2_WRITE_THROUGH_EN
          dirty_d[w_idx] = 1'b0;
`endif
          rdata_d = mem_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_HOLD;
      // L1 still holds its request during HOLD; it must not start a new transaction
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      for (int i = 0; i < NUM_OF_SET; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
`ifndef L2_WRITE_THROUGH_EN
        dirty_q[i] <= 1'b0;
`endif
      end
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
`ifndef L2_WRITE_THROUGH_EN
      dirty_q <= dirty_d;
`endif
    end
  end

  assign l1_ready = (state_q == ST_RESP);
  assign l1_rdata = rdata_q;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_MWR) begin
      mem_write = 1'b1;
`ifdef L2_WRITE_THROUGH_EN
      mem_addr  = l1_addr;
      mem_wdata = l1_wdata;
`else
      mem_addr  = {tag_q[w_idx], w_idx};
      mem_wdata = data_q[w_idx];
`endif
    end else if (state_q == ST_ALLOC) begin
      mem_read = 1'b1;
      mem_addr = l1_addr;
    end
  end

endmodule

`default_nettype wire
